// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_if
// Purpose  : Fetch-control and PC-status bundle between the IF stage and pc_gen.
// Revision : 1.0  initial release
// ============================================================================
interface pc_gen_if;
  logic        we;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        call;
  logic        ret;
  logic [31:0] instr_addr;
  logic [31:0] prev_addr;
  logic        halt;
  logic [1:0]  halt_cause;
  logic        ras_empty;
  logic        ras_full;

  // Master is the pipeline control driving the requests.
  modport master (
    output we, trap_valid, trap_vector, redirect_valid, redirect_addr, call, ret,
    input  instr_addr, prev_addr, halt, halt_cause, ras_empty, ras_full
  );

  modport slave (
    input  we, trap_valid, trap_vector, redirect_valid, redirect_addr, call, ret,
    output instr_addr, prev_addr, halt, halt_cause, ras_empty, ras_full
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program counter with trap/redirect priority, bounds and alignment
//            checking, halt state and a circular return-address stack.
// Revision : 1.0  initial release
// ============================================================================
module pc_gen #(
  parameter logic [31:0] RESET_ADDR = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter logic [31:0] IMEM_LAST  = 32'h0100_0FFC,
  parameter int          RAS_DEPTH  = 4
) (
  input  logic    clk,
  input  logic    rst,
  pc_gen_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_prev;
  logic               r_halt;
  logic [1:0]         r_cause;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_stack [RAS_DEPTH];

  logic [31:0] w_seq;
  logic [31:0] w_top;
  logic [31:0] w_cand;
  logic        w_ras_hit;
  logic        w_misaligned;
  logic        w_oob;
  logic        w_legal;
  logic        w_advance;
  logic        w_push;
  logic        w_replace;
  logic        w_pop;

  always_comb begin
    w_seq     = r_pc + 32'd4;
    w_top     = r_stack[r_ptr];
    w_ras_hit = bus.ret && (r_count != '0);

    if (bus.trap_valid)
      w_cand = bus.trap_vector;
    else if (bus.redirect_valid)
      w_cand = bus.redirect_addr;
    else if (w_ras_hit)
      w_cand = w_top;
    else
      w_cand = w_seq;

    w_misaligned = (w_cand[1:0] != 2'b00);
    w_oob        = (w_cand < IMEM_BASE) || (w_cand > IMEM_LAST);
    w_legal      = !w_misaligned && !w_oob;

    // The stack follows the instruction that actually retires into IF, so it
    // pops on ret even when a trap or redirect overrides the prediction.
    w_advance = (r_state == ST_RUN) && bus.we && w_legal;
    w_push    = w_advance && bus.call && !w_ras_hit;
    w_replace = w_advance && bus.call &&  w_ras_hit;
    w_pop     = w_advance && !bus.call && w_ras_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_ADDR;
      r_prev  <= RESET_ADDR;
      r_halt  <= 1'b0;
      r_cause <= 2'b00;
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.we) begin
            if (w_legal) begin
              r_prev <= r_pc;
              r_pc   <= w_cand;
            end else begin
              r_state <= ST_HALT;
              r_halt  <= 1'b1;
              r_cause <= w_misaligned ? 2'b10 : 2'b01;
            end
          end
        end
        ST_HALT: begin
          // trap_valid has top priority, so w_cand is trap_vector here.
          if (bus.trap_valid && w_legal) begin
            r_prev  <= r_pc;
            r_pc    <= w_cand;
            r_state <= ST_RUN;
            r_halt  <= 1'b0;
            r_cause <= 2'b00;
          end
        end
        default: begin
          r_state <= ST_HALT;
          r_halt  <= 1'b1;
        end
      endcase

      // Overflowing push wraps the pointer onto the oldest entry.
      if (w_push) begin
        r_ptr <= r_ptr + PTR_ONE;
        if (r_count != CNT_FULL)
          r_count <= r_count + CNT_ONE;
      end else if (w_pop) begin
        r_ptr   <= r_ptr - PTR_ONE;
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_stack[r_ptr + PTR_ONE] <= w_seq;
    else if (w_replace)
      r_stack[r_ptr] <= w_seq;
  end

  assign bus.instr_addr = r_pc;
  assign bus.prev_addr  = r_prev;
  assign bus.halt       = r_halt;
  assign bus.halt_cause = r_cause;
  assign bus.ras_empty  = (r_count == '0);
  assign bus.ras_full   = (r_count == CNT_FULL);

endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h0100_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_BASE, default 32'h0100_0000, meaning lowest legal fetch address.
REQ-003 SHALL have parameter IMEM_LAST, default 32'h0100_0FFC, meaning highest legal fetch address.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, 2..16).
REQ-005 SHALL have the port list below; one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous active-high reset
- we  in  1  advance PC this cycle (IF stage enable)
- trap_valid  in  1  trap/resume request
- trap_vector  in  32  trap target
- redirect_valid  in  1  taken branch/jump
- redirect_addr  in  32  branch/jump target
- call  in  1  current instruction is a call; push return address
- ret  in  1  current instruction is a return; predict from stack
- instr_addr  out  32  current fetch address
- prev_addr  out  32  fetch address before the last advance
- halt  out  1  block halted
- halt_cause  out  2  01 out-of-bounds, 10 misaligned, 00 none
- ras_empty  out  1  stack holds no entries
- ras_full  out  1  stack holds RAS_DEPTH entries

Function
REQ-006 SHALL implement two states, RUN and HALT; halt SHALL be 1 only in HALT.
REQ-007 In RUN with we=0, all registers SHALL hold.
REQ-008 In RUN with we=1, candidate next PC SHALL be selected by priority: trap_valid -> trap_vector; else redirect_valid -> redirect_addr; else ret with stack non-empty -> stack top; else instr_addr+4 (32-bit modulo, wraps to 0).
REQ-009 Candidate SHALL be legal only if IMEM_BASE <= cand <= IMEM_LAST and cand[1:0]==2'b00.
REQ-010 Legal candidate: instr_addr <= cand, prev_addr <= old instr_addr, next edge, single-cycle latency.
REQ-011 Illegal candidate: instr_addr and prev_addr SHALL hold, state -> HALT, halt_cause <= 10 if misaligned, else 01 (misaligned wins).
REQ-012 Stack updates SHALL occur only when we=1 and the candidate is legal.
REQ-013 ret with non-empty stack SHALL pop one entry; ret with empty stack SHALL not pop and SHALL fall back per REQ-008 priority.
REQ-014 call SHALL push instr_addr+4.
REQ-015 call and ret in the same cycle SHALL replace top with instr_addr+4, count unchanged; if empty, SHALL push only.
REQ-016 Push when full SHALL discard the oldest entry; count stays RAS_DEPTH, ras_full stays 1.
REQ-017 Trap or redirect with ret set SHALL still pop (misprediction does not preserve the stack).
REQ-018 In HALT, we, redirect_valid, call, ret SHALL be ignored; stack SHALL hold.
REQ-019 In HALT, trap_valid with legal trap_vector SHALL load instr_addr <= trap_vector, prev_addr <= old instr_addr, halt_cause <= 00, state -> RUN next edge; illegal trap_vector SHALL leave state, halt_cause unchanged.
REQ-020 ras_empty and ras_full SHALL be registered-state decodes of the entry count, valid same cycle as count.

Reset
REQ-021 rst=1 at a rising edge SHALL set instr_addr=RESET_ADDR, prev_addr=RESET_ADDR, state RUN, halt=0, halt_cause=00, stack count 0 (ras_empty=1, ras_full=0), overriding all other inputs, including mid-HALT.
REQ-022 Stack entry contents SHALL need no reset; unread entries SHALL never reach outputs.

Verification
REQ-023 Reset then 3 cycles we=1 -> instr_addr 0x01000004, 0x01000008, 0x0100000C; prev_addr trails by one.
REQ-024 instr_addr=0x01000FFC, we=1 sequential -> instr_addr holds 0x01000FFC, halt=1, halt_cause=01; further we/redirect ignored.
REQ-025 redirect_valid, redirect_addr=0x01000102 -> halt=1, halt_cause=10 (misaligned and in-bounds); then trap_valid, trap_vector=0x01000040 -> instr_addr=0x01000040, halt=0, halt_cause=00.
REQ-026 At 0x01000010 call+redirect to 0x01000200, then at 0x01000204 ret -> instr_addr=0x01000014, ras_empty=1.
REQ-027 Five calls with RAS_DEPTH=4 -> ras_full=1; four rets return the four newest addresses; fifth ret (empty) -> sequential +4.
REQ-028 trap_valid and redirect_valid together, we=1 -> instr_addr=trap_vector; rst asserted same cycle -> instr_addr=0x01000000.
